// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake from the source plus frame/strobe controls to the shift register
interface uart_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [10:0] data_frame;
  logic load;
  logic shift;
  logic baud_clk;
  logic busy;
  logic tx_done;
  modport master(output tx_data, tx_valid, input tx_ready, data_frame, load, shift, baud_clk, busy, tx_done);
  modport slave(input tx_data, tx_valid, output tx_ready, data_frame, load, shift, baud_clk, busy, tx_done);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences the 11-bit UART shift register from a one-entry byte buffer
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clk,
  input logic reset,
  uart_tx_if.slave bus
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [3:0] NBITS = PAR_EN ? 4'd12 : 4'd11;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state, next;
  logic hold_full;
  logic [7:0] hold;
  logic [BW-1:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic accept, tick, last;
  function automatic logic [10:0] frame(input logic [7:0] d);
    return {1'b0, d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7], PAR_EN ? (^d ^ PARITY_ODD) : 1'b1, 1'b1};
  endfunction
  always_comb begin
    accept = bus.tx_valid && !hold_full;
    tick = state == SEND && baud_cnt == BW'(CLKS_PER_BIT - 1);
    last = tick && bit_cnt == NBITS - 4'd1;
    next = state == IDLE ? (hold_full ? LOAD : IDLE) :
           state == LOAD ? SEND :
           last ? ((hold_full || accept) ? LOAD : IDLE) : SEND;
    bus.tx_ready = !hold_full;
    bus.load = state == LOAD;
    bus.shift = state == SEND;
    bus.baud_clk = tick;
    bus.tx_done = last;
    bus.busy = state != IDLE || hold_full;
  end
  // The frame is captured on entry to LOAD so it is valid while load is high;
  // a byte accepted on the final tick bypasses the hold register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      hold_full <= 1'b0;
      hold <= 8'h00;
      baud_cnt <= '0;
      bit_cnt <= 4'd0;
      bus.data_frame <= 11'h7FF;
    end else begin
      state <= next;
      if (state == LOAD) hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
      if (accept) hold <= bus.tx_data;
      if (next == LOAD) bus.data_frame <= frame(hold_full ? hold : bus.tx_data);
      baud_cnt <= (state != SEND || tick) ? '0 : baud_cnt + 1'b1;
      bit_cnt <= state != SEND ? 4'd0 : bit_cnt + {3'b000, tick};
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed checks of three controller instances against a shift-register model
module tb_uart_tx_ctrl;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 12;
  localparam bit PEN = 1'b1;
`else
  localparam int NB = 11;
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  uart_tx_if a();
  uart_tx_if b();
  uart_tx_if c();
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_a (.clk(clk), .reset(reset), .bus(a));
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_b (.clk(clk), .reset(reset), .bus(b));
  uart_tx_ctrl #(.CLKS_PER_BIT(2), .PARITY_ODD(1'b0)) u_c (.clk(clk), .reset(reset), .bus(c));
  logic [10:0] sr_a = 11'h7FF, sr_c = 11'h7FF;
  logic tx_a = 1'b1, tx_c = 1'b1;
  int tick_a[$], load_a[$], done_a[$], tick_c[$], load_c[$], done_c[$];
  logic [10:0] frm_a[$], frm_c[$];
  logic bits_a[$];
  // Shift-register model: load wins, idle forces all-ones, each tick moves sr[10] onto tx
  always @(negedge clk) begin
    cyc++;
    if (a.baud_clk) tick_a.push_back(cyc);
    if (a.tx_done) done_a.push_back(cyc);
    if (a.load) begin load_a.push_back(cyc); frm_a.push_back(a.data_frame); sr_a = a.data_frame; end
    else if (!a.shift) begin sr_a = 11'h7FF; tx_a = 1'b1; end
    else if (a.baud_clk) begin bits_a.push_back(sr_a[10]); tx_a = sr_a[10]; sr_a = {sr_a[9:0], 1'b1}; end
    if (c.baud_clk) tick_c.push_back(cyc);
    if (c.tx_done) done_c.push_back(cyc);
    if (c.load) begin load_c.push_back(cyc); frm_c.push_back(c.data_frame); sr_c = c.data_frame; end
    else if (!c.shift) begin sr_c = 11'h7FF; tx_c = 1'b1; end
    else if (c.baud_clk) begin tx_c = sr_c[10]; sr_c = {sr_c[9:0], 1'b1}; end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  function automatic logic [10:0] exp_frame(input logic [7:0] d, input bit po);
    logic [10:0] f = 11'h7FF;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[9-i] = d[i];
    f[1] = PEN ? ((^d) ^ po) : 1'b1;
    return f;
  endfunction
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic clear_logs();
    tick_a.delete(); load_a.delete(); done_a.delete(); frm_a.delete(); bits_a.delete();
    tick_c.delete(); load_c.delete(); done_c.delete(); frm_c.delete();
  endtask
  task automatic drive(input int s, input logic v, input logic [7:0] d);
    if (s == 0) begin a.tx_valid = v; a.tx_data = d; end
    else if (s == 1) begin b.tx_valid = v; b.tx_data = d; end
    else begin c.tx_valid = v; c.tx_data = d; end
  endtask
  function automatic logic rdy(input int s);
    return s == 0 ? a.tx_ready : s == 1 ? b.tx_ready : c.tx_ready;
  endfunction
  function automatic logic bsy(input int s);
    return s == 0 ? a.busy : s == 1 ? b.busy : c.busy;
  endfunction
  task automatic offer(input int s, input logic [7:0] d, input bit scramble);
    int n = 0;
    while (!rdy(s) && n < 400) begin drive(s, 1'b1, scramble ? 8'($urandom) : d); step(); n++; end
    drive(s, 1'b1, d);
    step();
    drive(s, 1'b0, ~d);
    total++; if (n >= 400) $display("FAIL offer_timeout dut=%0d byte=%h waited=%0d limit=400", s, d, n); else passed++;
  endtask
  task automatic wait_idle(input int s);
    int n = 0;
    while (bsy(s) && n < 2000) begin step(); n++; end
    total++; if (n >= 2000) $display("FAIL idle_timeout dut=%0d waited=%0d limit=2000", s, n); else passed++;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    total++; if (a.load !== 1'b0) $display("FAIL rst_load got %b want 0", a.load); else passed++;
    total++; if (a.shift !== 1'b0) $display("FAIL rst_shift got %b want 0", a.shift); else passed++;
    total++; if (a.baud_clk !== 1'b0) $display("FAIL rst_baud got %b want 0", a.baud_clk); else passed++;
    total++; if (a.tx_done !== 1'b0) $display("FAIL rst_done got %b want 0", a.tx_done); else passed++;
    total++; if (a.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", a.busy); else passed++;
    total++; if (a.tx_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", a.tx_ready); else passed++;
    total++; if (a.data_frame !== 11'h7FF) $display("FAIL rst_frame got %h want 7ff", a.data_frame); else passed++;
    reset = 1'b1;
    step();
    offer(0, 8'hA5, 1'b0);
    offer(0, 8'h3C, 1'b0);
    repeat (10) step();
    total++; if (a.shift !== 1'b1) $display("FAIL pre_abort_shift got %b want 1", a.shift); else passed++;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    total++; if (a.load !== 1'b0 || a.shift !== 1'b0) $display("FAIL abort_ctl got load=%b shift=%b want 0 0", a.load, a.shift); else passed++;
    total++; if (tx_a !== 1'b1) $display("FAIL abort_tx got %b want 1", tx_a); else passed++;
    total++; if (a.tx_ready !== 1'b1 || a.busy !== 1'b0) $display("FAIL abort_hs got ready=%b busy=%b want 1 0", a.tx_ready, a.busy); else passed++;
    total++; if (a.data_frame !== 11'h7FF) $display("FAIL abort_frame got %h want 7ff", a.data_frame); else passed++;
    clear_logs();
    repeat (20) step();
    total++; if (load_a.size() != 0) $display("FAIL abort_discard got %0d loads want 0", load_a.size()); else passed++;
  endtask
  task automatic test_single();
    logic [11:0] seq = PEN ? {11'h295, 1'b1} : {11'h297, 1'b1};
    int bad = 0;
    clear_logs();
    offer(0, 8'hA5, 1'b0);
    wait_idle(0);
    total++; if (frm_a.size() != 1 || frm_a[0] !== (PEN ? 11'h295 : 11'h297)) $display("FAIL single_frame got n=%0d f=%h want 1 %h", frm_a.size(), frm_a[0], PEN ? 11'h295 : 11'h297); else passed++;
    total++; if (tick_a.size() != NB) $display("FAIL single_ticks got %0d want %0d", tick_a.size(), NB); else passed++;
    if (tick_a.size() > 0 && tick_a[0] - load_a[0] != 4) bad++;
    for (int i = 1; i < tick_a.size(); i++) if (tick_a[i] - tick_a[i-1] != 4) bad++;
    total++; if (bad != 0) $display("FAIL single_spacing got %0d bad gaps want 0", bad); else passed++;
    bad = 0;
    for (int i = 0; i < bits_a.size() && i < NB; i++) if (bits_a[i] !== seq[11-i]) bad++;
    total++; if (bad != 0 || bits_a.size() != NB) $display("FAIL single_txseq got %0d bad of %0d want 0 of %0d", bad, bits_a.size(), NB); else passed++;
    total++; if (done_a.size() != 1 || done_a[0] != tick_a[NB-1]) $display("FAIL single_done got n=%0d at %0d want 1 at last tick", done_a.size(), done_a[0]); else passed++;
    total++; if (tx_a !== 1'b1) $display("FAIL single_tx_idle got %b want 1", tx_a); else passed++;
  endtask
  task automatic test_parity_odd();
    int n = 0;
    offer(1, 8'h00, 1'b0);
    while (!b.load && n < 50) begin step(); n++; end
    total++; if (b.data_frame !== 11'h003) $display("FAIL odd_00 got %h want 003", b.data_frame); else passed++;
    wait_idle(1);
    n = 0;
    offer(1, 8'h01, 1'b0);
    while (!b.load && n < 50) begin step(); n++; end
    total++; if (b.data_frame !== (PEN ? 11'h201 : 11'h203)) $display("FAIL odd_01 got %h want %h", b.data_frame, PEN ? 11'h201 : 11'h203); else passed++;
    wait_idle(1);
  endtask
  task automatic test_back_to_back();
    int n = 0;
    clear_logs();
    offer(0, 8'h3C, 1'b0);
    repeat (6) step();
    offer(0, 8'hC3, 1'b0);
    total++; if (a.tx_ready !== 1'b0) $display("FAIL b2b_ready_held got %b want 0", a.tx_ready); else passed++;
    while (load_a.size() < 2 && n < 200) begin step(); n++; end
    total++; if (a.load !== 1'b1 || a.tx_ready !== 1'b0) $display("FAIL b2b_in_load got load=%b ready=%b want 1 0", a.load, a.tx_ready); else passed++;
    step();
    total++; if (a.tx_ready !== 1'b1) $display("FAIL b2b_ready_after got %b want 1", a.tx_ready); else passed++;
    n = 0;
    while (!a.tx_done && n < 200) begin step(); n++; end
    drive(0, 1'b1, 8'h99);
    step();
    drive(0, 1'b0, 8'h00);
    total++; if (a.load !== 1'b1) $display("FAIL b2b_final_tick_accept got load=%b want 1", a.load); else passed++;
    wait_idle(0);
    total++; if (load_a.size() != 3 || done_a.size() != 3) $display("FAIL b2b_count got loads=%0d dones=%0d want 3 3", load_a.size(), done_a.size()); else passed++;
    total++; if (load_a[1] - load_a[0] != NB * 4 + 1) $display("FAIL b2b_gap got %0d want %0d", load_a[1] - load_a[0], NB * 4 + 1); else passed++;
    total++; if (load_a[1] != done_a[0] + 1 || load_a[2] != done_a[1] + 1) $display("FAIL b2b_load_after_done got %0d,%0d want %0d,%0d", load_a[1], load_a[2], done_a[0] + 1, done_a[1] + 1); else passed++;
    total++; if (frm_a[0] !== exp_frame(8'h3C, 1'b0) || frm_a[1] !== exp_frame(8'hC3, 1'b0) || frm_a[2] !== exp_frame(8'h99, 1'b0)) $display("FAIL b2b_frames got %h %h %h want %h %h %h", frm_a[0], frm_a[1], frm_a[2], exp_frame(8'h3C, 1'b0), exp_frame(8'hC3, 1'b0), exp_frame(8'h99, 1'b0)); else passed++;
  endtask
  task automatic test_hold_full();
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h55};
    clear_logs();
    for (int i = 0; i < 3; i++) offer(0, bytes[i], 1'b1);
    wait_idle(0);
    total++; if (frm_a.size() != 3 || done_a.size() != 3) $display("FAIL hold_count got frames=%0d dones=%0d want 3 3", frm_a.size(), done_a.size()); else passed++;
    for (int i = 0; i < 3 && i < frm_a.size(); i++) begin
      total++; if (frm_a[i] !== exp_frame(bytes[i], 1'b0)) $display("FAIL hold_frame%0d got %h want %h", i, frm_a[i], exp_frame(bytes[i], 1'b0)); else passed++;
    end
  endtask
  task automatic test_min_baud();
    int bad = 0;
    clear_logs();
    offer(2, 8'h81, 1'b0);
    repeat (3) step();
    offer(2, 8'h7E, 1'b0);
    wait_idle(2);
    total++; if (done_c.size() != 2 || tick_c.size() != 2 * NB) $display("FAIL min_counts got dones=%0d ticks=%0d want 2 %0d", done_c.size(), tick_c.size(), 2 * NB); else passed++;
    for (int i = 1; i < tick_c.size(); i++) if (tick_c[i] - tick_c[i-1] != (i == NB ? 3 : 2)) bad++;
    total++; if (bad != 0) $display("FAIL min_spacing got %0d bad gaps want 0", bad); else passed++;
    total++; if (done_c[0] - load_c[0] != NB * 2) $display("FAIL min_frame_len got %0d want %0d", done_c[0] - load_c[0], NB * 2); else passed++;
    total++; if (load_c[1] != done_c[0] + 1) $display("FAIL min_b2b got %0d want %0d", load_c[1], done_c[0] + 1); else passed++;
    total++; if (frm_c[0] !== exp_frame(8'h81, 1'b0) || frm_c[1] !== exp_frame(8'h7E, 1'b0)) $display("FAIL min_frames got %h %h want %h %h", frm_c[0], frm_c[1], exp_frame(8'h81, 1'b0), exp_frame(8'h7E, 1'b0)); else passed++;
    total++; if (tx_c !== 1'b1) $display("FAIL min_tx_idle got %b want 1", tx_c); else passed++;
  endtask
  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    test_reset();
    test_single();
    test_parity_odd();
    test_back_to_back();
    test_hold_full();
    test_min_baud();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
